// File: rtl/layer_sequencer.sv
// Sequences one shared signed MAC through a fully-connected layer: stream the
// activation/weight pairs, add the bias, apply ReLU, rescale, saturate and write.
//
// state  | meaning
// IDLE   | waiting for start, MAC held clear
// FETCH  | issue activation/weight address i for the current neuron
// DRAIN  | last pair reaches the MAC and is accumulated
// RESULT | MAC output final; activation registered at end of cycle
// WRITE  | out_we for the current neuron, then next neuron or DONE
// DONE   | one-cycle done pulse
module layer_sequencer #(
   parameter int WIDTH     = 8,
   parameter int N_INPUTS  = 16,
   parameter int N_NEURONS = 10,
   parameter int FRAC      = 4,
   parameter int ACC_W     = 2*WIDTH + $clog2(N_INPUTS) + 1
) (
   input  logic                                    clk,
   input  logic                                    aclr,
   input  logic                                    start,
   output logic                                    busy,
   output logic                                    done,
   output logic [$clog2(N_INPUTS)-1:0]             in_addr,
   output logic [$clog2(N_INPUTS*N_NEURONS)-1:0]   w_addr,
   output logic [((N_NEURONS > 1) ? $clog2(N_NEURONS) : 1)-1:0] b_addr,
   input  logic signed [2*WIDTH-1:0]               bias,
   output logic                                    mac_clken,
   output logic                                    mac_sload,
   output logic                                    mac_aclr,
   input  logic signed [ACC_W-1:0]                 mac_result,
   output logic                                    out_we,
   output logic [((N_NEURONS > 1) ? $clog2(N_NEURONS) : 1)-1:0] out_addr,
   output logic signed [WIDTH-1:0]                 out_data
);

   localparam int IW  = $clog2(N_INPUTS);
   localparam int NW  = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
   localparam int WAW = $clog2(N_INPUTS*N_NEURONS);
   localparam logic signed [ACC_W:0] MAX_OUT = (ACC_W+1)'((2**(WIDTH-1)) - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DRAIN, S_RESULT, S_WRITE, S_DONE
   } state_t;

   state_t                   r_state, w_next;
   logic [IW-1:0]            r_i;
   logic [NW-1:0]            r_neuron;
   logic [WAW-1:0]           r_waddr;
   logic                     r_clken, r_sload;
   logic signed [WIDTH-1:0]  r_out_data;
   logic signed [ACC_W:0]    w_sum, w_q;
   logic signed [WIDTH-1:0]  w_act;
   logic                     w_last_i, w_last_n;

   assign w_last_i = (r_i == IW'(N_INPUTS - 1));
   assign w_last_n = (r_neuron == NW'(N_NEURONS - 1));

   always_ff @(posedge clk) begin
      if (aclr) begin
         r_state    <= S_IDLE;
         r_i        <= '0;
         r_neuron   <= '0;
         r_waddr    <= '0;
         r_clken    <= 1'b0;
         r_sload    <= 1'b0;
         r_out_data <= '0;
      end else begin
         r_state <= w_next;
         // the MAC sees data one cycle after the address, so enables trail FETCH by one
         r_clken <= (r_state == S_FETCH);
         r_sload <= (r_state == S_FETCH) && (r_i == '0);
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_i      <= '0;
                  r_neuron <= '0;
                  r_waddr  <= '0;
               end
            end
            S_FETCH: begin
               r_i     <= w_last_i ? '0 : r_i + 1'b1;
               r_waddr <= r_waddr + 1'b1;
            end
            S_RESULT: r_out_data <= w_act;
            S_WRITE: begin
               if (!w_last_n) r_neuron <= r_neuron + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next   = r_state;
      busy     = (r_state != S_IDLE);
      done     = 1'b0;
      out_we   = 1'b0;
      mac_aclr = aclr || (r_state == S_IDLE);
      case (r_state)
         S_IDLE:   if (start) w_next = S_FETCH;
         S_FETCH:  if (w_last_i) w_next = S_DRAIN;
         S_DRAIN:  w_next = S_RESULT;
         S_RESULT: w_next = S_WRITE;
         S_WRITE: begin
            out_we = 1'b1;
            w_next = w_last_n ? S_DONE : S_FETCH;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_sum = $signed({mac_result[ACC_W-1], mac_result})
            + $signed({{(ACC_W+1-2*WIDTH){bias[2*WIDTH-1]}}, bias});
      w_q   = w_sum >>> FRAC;
      w_act = '0;
      if (w_sum[ACC_W])        w_act = '0;
      else if (w_q > MAX_OUT)  w_act = MAX_OUT[WIDTH-1:0];
      else                     w_act = w_q[WIDTH-1:0];
   end

   assign in_addr   = r_i;
   assign w_addr    = r_waddr;
   assign b_addr    = r_neuron;
   assign out_addr  = r_neuron;
   assign mac_clken = r_clken;
   assign mac_sload = r_sload;
   assign out_data  = r_out_data;

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomised scoreboard bench for layer_sequencer with memory and MAC models
// around the DUT and an arithmetic reference of each neuron's output.
module tb_layer_sequencer;

   localparam int WIDTH = 8;
   localparam int FRAC  = 4;
   localparam int NI    = 4;
   localparam int NN    = 2;
   localparam int ACC_W = 2*WIDTH + $clog2(NI) + 1;
   localparam int LAT   = NN*(NI+3);

   logic clk = 1'b0;
   logic aclr, start;
   logic busy, done, mac_clken, mac_sload, mac_aclr, out_we;
   logic [1:0] in_addr;
   logic [2:0] w_addr;
   logic [0:0] b_addr, out_addr;
   logic signed [2*WIDTH-1:0] bias;
   logic signed [ACC_W-1:0]   mac_result;
   logic signed [WIDTH-1:0]   out_data;

   always #5 clk = ~clk;

   layer_sequencer #(.WIDTH(WIDTH), .N_INPUTS(NI), .N_NEURONS(NN), .FRAC(FRAC)) dut (
      .clk(clk), .aclr(aclr), .start(start), .busy(busy), .done(done),
      .in_addr(in_addr), .w_addr(w_addr), .b_addr(b_addr), .bias(bias),
      .mac_clken(mac_clken), .mac_sload(mac_sload), .mac_aclr(mac_aclr),
      .mac_result(mac_result), .out_we(out_we), .out_addr(out_addr),
      .out_data(out_data));

   // layer memories with one-cycle read latency, and the shared MAC
   logic signed [WIDTH-1:0]   act_mem [NI];
   logic signed [WIDTH-1:0]   wgt_mem [NI*NN];
   logic signed [2*WIDTH-1:0] bias_mem [NN];
   logic signed [WIDTH-1:0]   a_q, w_q;
   logic signed [2*WIDTH-1:0] prod;
   logic signed [ACC_W-1:0]   acc;

   always @(posedge clk) begin
      a_q  <= act_mem[in_addr];
      w_q  <= wgt_mem[w_addr];
      bias <= bias_mem[b_addr];
   end
   assign prod = a_q * w_q;
   always @(posedge clk) begin
      if (mac_aclr)       acc <= '0;
      else if (mac_clken) acc <= (mac_sload ? '0 : acc) + {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
   end
   assign mac_result = acc;

   typedef struct { int addr; int data; } exp_t;
   exp_t sb[$];
   int checks = 0, failures = 0;
   int cyc = 0, exp_done = -1, done_cnt = 0, wr_cnt = 0, clk_cnt = 0;
   bit sload_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int model_out(input int n);
      int s;
      s = int'(bias_mem[n]);
      for (int i = 0; i < NI; i++) s += int'(act_mem[i]) * int'(wgt_mem[n*NI+i]);
      if (s < 0) return 0;
      s = s / (1 << FRAC);
      return (s > 127) ? 127 : s;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : monitor
      exp_t e;
      if (aclr) begin
         clk_cnt   = 0;
         sload_bad = 0;
      end else begin
         if (mac_clken) begin
            if (mac_sload != (clk_cnt == 0)) sload_bad = 1;
            clk_cnt++;
         end else if (mac_sload) sload_bad = 1;
         if (out_we) begin
            wr_cnt++;
            if (sb.size() == 0) check("unexpected_write", int'(out_we), 0);
            else begin
               e = sb.pop_front();
               check("out_addr", int'(out_addr), e.addr);
               check("out_data", int'(out_data), e.data);
            end
            check("clken_cycles", clk_cnt, NI);
            check("sload_first_only", int'(sload_bad), 0);
            clk_cnt   = 0;
            sload_bad = 0;
         end
         if (done) begin
            done_cnt++;
            check("done_latency", cyc, exp_done);
            check("pending_at_done", sb.size(), 0);
            exp_done = -1;
         end else if (exp_done >= 0 && cyc == exp_done) begin
            check("done_missing", int'(done), 1);
         end
      end
   end

   task automatic set_mem(input int a, input int w0, input int w1, input int b0, input int b1);
      for (int i = 0; i < NI; i++) begin
         act_mem[i]      = WIDTH'(a);
         wgt_mem[i]      = WIDTH'(w0);
         wgt_mem[NI + i] = WIDTH'(w1);
      end
      bias_mem[0] = (2*WIDTH)'(b0);
      bias_mem[1] = (2*WIDTH)'(b1);
   endtask

   task automatic issue_start(output int w0, output int d0);
      @(negedge clk);
      start = 1'b1;
      for (int n = 0; n < NN; n++) sb.push_back('{addr: n, data: model_out(n)});
      w0 = wr_cnt;
      d0 = done_cnt;
      @(negedge clk);
      start    = 1'b0;
      exp_done = cyc + LAT;
      check("busy_after_start", int'(busy), 1);
   endtask

   task automatic run_pass(input int restart_at);
      int w0, d0;
      issue_start(w0, d0);
      for (int k = 1; k < LAT + 40 && done_cnt == d0; k++) begin
         if (k == restart_at) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      repeat (5) @(negedge clk);
      check("writes_per_pass", wr_cnt - w0, NN);
      check("done_per_pass", done_cnt - d0, 1);
      check("idle_after_done", int'(busy), 0);
      check("leftover_expected", sb.size(), 0);
      sb.delete();
      exp_done = -1;
   endtask

   task automatic abort_pass();
      int w0, d0;
      issue_start(w0, d0);
      repeat (8) @(negedge clk);
      aclr = 1'b1;
      sb.delete();
      exp_done = -1;
      @(negedge clk);
      check("abort_busy", int'(busy), 0);
      check("abort_mac_aclr", int'(mac_aclr), 1);
      check("abort_clken", int'(mac_clken), 0);
      aclr = 1'b0;
      repeat (30) @(negedge clk);
      check("abort_writes", wr_cnt - w0, 1);
      check("abort_done", done_cnt - d0, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      aclr  = 1'b1;
      start = 1'b0;
      set_mem(16, 16, 16, 0, 0);
      repeat (3) @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_clken", int'(mac_clken), 0);
      check("rst_sload", int'(mac_sload), 0);
      check("rst_out_we", int'(out_we), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_out_addr", int'(out_addr), 0);
      check("rst_in_addr", int'(in_addr), 0);
      check("rst_w_addr", int'(w_addr), 0);
      check("rst_b_addr", int'(b_addr), 0);
      check("rst_mac_aclr", int'(mac_aclr), 1);
      aclr = 1'b0;
      @(negedge clk);
      check("idle_mac_aclr", int'(mac_aclr), 1);

      // start coinciding with reset must not launch a pass
      aclr  = 1'b1;
      start = 1'b1;
      @(negedge clk);
      aclr  = 1'b0;
      start = 1'b0;
      check("aclr_wins_busy", int'(busy), 0);
      @(negedge clk);
      check("aclr_wins_idle", int'(busy), 0);

      set_mem(16, 16, 16, 0, 0);       run_pass(0);
      set_mem(16, 16, 16, -512, 0);    run_pass(0);
      set_mem(16, -16, 16, 0, 0);      run_pass(0);
      set_mem(127, 127, 127, 0, 0);    run_pass(0);
      set_mem(16, 16, 16, 0, 0);       run_pass(3);
      abort_pass();
      run_pass(0);

      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < NI; i++) act_mem[i] = WIDTH'($urandom);
         for (int i = 0; i < NI*NN; i++) wgt_mem[i] = WIDTH'($urandom);
         for (int n = 0; n < NN; n++) bias_mem[n] = (2*WIDTH)'($urandom);
         run_pass((r % 3 == 0) ? int'($urandom_range(1, LAT)) : 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
